sar_logic10: RTL and testbench
==============================

// Module: sar_logic10
// PURPOSE
//  Synchronous SAR conversion controller that drives the bootstrapped sampling switch and consumes its sampled charge.
//  It generates the switch sampling clock (SMP_CK) and strobes the comparator.
//  It runs the binary search on the capacitive DAC and delivers the NBIT result with a valid pulse.
//  Sits between the analog front end (sampling switch, CDAC, comparator) and the digital back end.
// PARAMETERS
//  NBIT     10  resolution; number of bit trials per conversion
//  SMP_CYC   3  CK cycles SMP_CK is held high (sampling window); legal range 1..15
// PORTS
//  CK       in   1     system clock; all logic on rising edge
//  RSTN     in   1     synchronous reset, active low
//  START    in   1     request one conversion; sampled only in IDLE or DONE
//  CONT     in   1     1 = free-run: DONE restarts sampling without START
//  CMP_OUT  in   1     comparator decision, 1 = VIN >= DAC trial; valid by end of EVAL cycle
//  SMP_CK   out  1     to sampling switch CK; 1 = track, 0 = hold
//  CMP_CK   out  1     comparator strobe; high for one cycle per bit (STRB)
//  DACP     out  NBIT  CDAC trial code
//  DOUT     out  NBIT  last completed result; held until next DONE
//  DVALID   out  1     one-cycle pulse; DOUT updated in the same cycle
//  BUSY     out  1     1 in SAMPLE/CONV
// BEHAVIOUR
//  - Clock: single clock CK. Reset: RSTN is synchronous and active low.
//  - Reset: all outputs are registered, and all are 0 after any edge with RSTN=0: SMP_CK, CMP_CK, DACP, DOUT, DVALID, BUSY. State becomes IDLE.
//  - RSTN low mid-conversion aborts immediately. The partial code is discarded, SMP_CK drops, and no DVALID is issued.
//  - FSM states: IDLE, SAMPLE, STRB, EVAL, DONE.
//    IDLE:   START=1 -> SAMPLE; else stay.
//    SAMPLE: SMP_CK=1 and DACP=0 for exactly SMP_CYC cycles, then -> STRB with bit pointer i = NBIT-1.
//    STRB:   CMP_CK=1; DACP = {decided bits above i, 1 at i, 0 below i}. -> EVAL.
//    EVAL:   CMP_CK=0 and DACP held. At the closing edge, bit i <= CMP_OUT.
//            i>0 -> STRB with i-1; i=0 -> DONE.
//    DONE:   DOUT <= final code, DVALID=1, DACP = final code.
//            START|CONT -> SAMPLE; else -> IDLE.
//  - SMP_CK is 0 in every state except SAMPLE. SMP_CK falls on the edge entering the first STRB, so hold begins before any strobe.
//  - Latency: DVALID rises SMP_CYC + 2*NBIT edges after the edge that captures START (defaults: 23).
//  - Free-run period is 1 + SMP_CYC + 2*NBIT cycles (defaults: 24).
//  - START while BUSY is ignored, not queued.
//  - START and CONT both high in DONE give a single restart.
//  - CMP_OUT is sampled only at the end of EVAL; it is don't-care elsewhere.
//  - The bit pointer never wraps. There is no state in which i underflows; unused encodings -> IDLE.
// STRUCTURE
//  - Package sar_pkg: typedef enum sar_state_t {IDLE, SAMPLE, STRB, EVAL, DONE}, localparam NBIT_DEF=10, SMP_CYC_DEF=3.
//  - Sub-module sar_bit_ptr: one-hot down-shifting pointer with load and done flag, NBIT wide.
//  - The FSM, sample counter ($clog2(SMP_CYC+1) bits) and code register stay in sar_logic10.
// TESTING
//  (bench comparator model: CMP_OUT = (VIN_CODE >= DACP), evaluated in EVAL)
//  1. RSTN=0 for 2 cycles, then 1, START=0 -> all outputs 0, BUSY=0, indefinitely.
//  2. VIN_CODE=0x2A5, START pulse -> SMP_CK high 3 cycles, 10 CMP_CK pulses, DVALID at +23 edges, DOUT=0x2A5, BUSY=0 after.
//  3. VIN_CODE=0x000, then 0x3FF -> DOUT=0x000 and 0x3FF; first DACP trial = 0x200 in both.
//  4. START reasserted in SAMPLE and in EVAL of bit 5 -> ignored; exactly one DVALID, timing as scenario 2.
//  5. RSTN=0 during STRB of bit 5 -> next cycle all outputs 0 and state IDLE; fresh START then converts 0x155 correctly.
//  6. CONT=1, VIN_CODE stepped 0x001 -> 0x1FF -> 0x200 -> DVALID every 24 cycles, DOUT tracks each code, SMP_CK low during every STRB/EVAL.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and defaults for the 10-bit SAR conversion controller.
package sar_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    STRB   = 3'd2,
    EVAL   = 3'd3,
    DONE   = 3'd4
  } sar_state_t;

  localparam int unsigned NBIT_DEF    = 10;
  localparam int unsigned SMP_CYC_DEF = 3;

endpackage

// File: rtl/sar_logic10_if.sv
// Handshake and analog-front-end signals between the SAR controller and its surroundings.
interface sar_logic10_if #(
  parameter int unsigned NBIT = 10
);
  logic            START;
  logic            CONT;
  logic            CMP_OUT;
  logic            SMP_CK;
  logic            CMP_CK;
  logic [NBIT-1:0] DACP;
  logic [NBIT-1:0] DOUT;
  logic            DVALID;
  logic            BUSY;

  // Controller side
  modport master (
    input  START, CONT, CMP_OUT,
    output SMP_CK, CMP_CK, DACP, DOUT, DVALID, BUSY
  );

  // Front end / back end side
  modport slave (
    output START, CONT, CMP_OUT,
    input  SMP_CK, CMP_CK, DACP, DOUT, DVALID, BUSY
  );
endinterface

// File: rtl/sar_bit_ptr.sv
// One-hot bit-trial pointer: loads at the MSB, shifts down one bit per trial.
module sar_bit_ptr #(
  parameter int unsigned NBIT = 10
) (
  input  logic            CK,
  input  logic            RSTN,
  input  logic            load_i,
  input  logic            shift_i,
  output logic [NBIT-1:0] ptr_o,
  output logic            last_o
);

  localparam logic [NBIT-1:0] MSB_ONE = {1'b1, {(NBIT-1){1'b0}}};

  logic [NBIT-1:0] ptr_q, ptr_d;

  // Next pointer: load wins over shift
  always_comb begin
    ptr_d = ptr_q;
    if (load_i)       ptr_d = MSB_ONE;
    else if (shift_i) ptr_d = ptr_q >> 1;
  end

  // Pointer register with synchronous active-low reset
  always_ff @(posedge CK) begin
    if (!RSTN) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o  = ptr_q;
  assign last_o = ptr_q[0];

endmodule

// File: rtl/sar_logic10.sv
// SAR conversion controller: sampling window, comparator strobes, binary search, result delivery.
module sar_logic10
  import sar_pkg::*;
#(
  parameter int unsigned NBIT    = NBIT_DEF,
  parameter int unsigned SMP_CYC = SMP_CYC_DEF
) (
  input  logic          CK,
  input  logic          RSTN,
  sar_logic10_if.master bus
);

  localparam int unsigned     CW       = $clog2(SMP_CYC + 1);
  localparam logic [CW-1:0]   SMP_LAST = CW'(SMP_CYC - 1);
  localparam logic [NBIT-1:0] MSB_ONE  = {1'b1, {(NBIT-1){1'b0}}};

  sar_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NBIT-1:0] code_q, code_d;
  logic [NBIT-1:0] dacp_q, dacp_d;
  logic [NBIT-1:0] dout_q, dout_d;
  logic            smp_q, smp_d;
  logic            cmpck_q, cmpck_d;
  logic            dvalid_q, dvalid_d;
  logic            busy_q, busy_d;

  logic            ptr_load, ptr_shift, ptr_last;
  logic [NBIT-1:0] ptr;

  sar_bit_ptr #(.NBIT(NBIT)) u_ptr (
    .CK      (CK),
    .RSTN    (RSTN),
    .load_i  (ptr_load),
    .shift_i (ptr_shift),
    .ptr_o   (ptr),
    .last_o  (ptr_last)
  );

  // Next state, next code/trial and registered-output next values
  // Outputs are derived from state_d so every port is a flop that matches the state it reports.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    dacp_d    = dacp_q;
    dout_d    = dout_q;
    ptr_load  = 1'b0;
    ptr_shift = 1'b0;

    unique case (state_q)
      IDLE: begin
        dacp_d = '0;
        if (bus.START) begin
          state_d = SAMPLE;
          cnt_d   = '0;
          code_d  = '0;
        end
      end
      SAMPLE: begin
        dacp_d = '0;
        if (cnt_q == SMP_LAST) begin
          state_d  = STRB;
          ptr_load = 1'b1;
          dacp_d   = MSB_ONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STRB: begin
        state_d = EVAL;
      end
      EVAL: begin
        code_d = code_q | (bus.CMP_OUT ? ptr : '0);
        if (ptr_last) begin
          state_d = DONE;
          dout_d  = code_d;
          dacp_d  = code_d;
        end else begin
          state_d   = STRB;
          ptr_shift = 1'b1;
          dacp_d    = code_d | (ptr >> 1);
        end
      end
      DONE: begin
        dacp_d = '0;
        if (bus.START || bus.CONT) begin
          state_d = SAMPLE;
          cnt_d   = '0;
          code_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        dacp_d  = '0;
      end
    endcase

    smp_d    = (state_d == SAMPLE);
    cmpck_d  = (state_d == STRB);
    dvalid_d = (state_d == DONE);
    busy_d   = (state_d == SAMPLE) || (state_d == STRB) || (state_d == EVAL);
  end

  // State and output registers; reset aborts any conversion in progress
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      dacp_q   <= '0;
      dout_q   <= '0;
      smp_q    <= 1'b0;
      cmpck_q  <= 1'b0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      dacp_q   <= dacp_d;
      dout_q   <= dout_d;
      smp_q    <= smp_d;
      cmpck_q  <= cmpck_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.SMP_CK = smp_q;
  assign bus.CMP_CK = cmpck_q;
  assign bus.DACP   = dacp_q;
  assign bus.DOUT   = dout_q;
  assign bus.DVALID = dvalid_q;
  assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_sar_logic10.sv
// Self-checking bench for sar_logic10 with an ideal comparator front end.
module tb_sar_logic10;

  localparam int NB      = 10;
  localparam int SMPC    = 3;
  localparam int LAT     = SMPC + 2 * NB;   // edges from START capture to DVALID
  localparam int PERIOD  = 1 + SMPC + 2 * NB;

  logic          CK;
  logic          RSTN;
  logic [NB-1:0] vin;
  logic          noise;

  int checks = 0;
  int passes = 0;

  sar_logic10_if #(.NBIT(NB)) bus ();

  sar_logic10 #(.NBIT(NB), .SMP_CYC(SMPC)) dut (
    .CK   (CK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  // Ideal comparator; random garbage while strobing, where the result must be ignored
  always @(negedge CK) noise <= 1'($urandom);
  assign bus.CMP_OUT = bus.CMP_CK ? noise : (vin >= bus.DACP);

  // Run one conversion: START captured at the first edge, optional extra START pulses
  task automatic do_conv(input logic [NB-1:0] v, input int pa, input int pb, input int max_cyc,
                         output int lat, output int smp_hi, output int nstrb,
                         output logic [NB-1:0] first_trial, output int ndv,
                         output logic [NB-1:0] dv_code, output logic overlap);
    vin = v; lat = -1; smp_hi = 0; nstrb = 0; first_trial = '0;
    ndv = 0; dv_code = '0; overlap = 1'b0;
    bus.START = 1'b1;
    for (int n = 1; n <= max_cyc; n++) begin
      @(posedge CK); #1;
      bus.START = (n == pa) || (n == pb);
      if (bus.SMP_CK) smp_hi++;
      if (bus.SMP_CK && bus.CMP_CK) overlap = 1'b1;
      if (bus.CMP_CK) begin
        if (nstrb == 0) first_trial = bus.DACP;
        nstrb++;
      end
      if (bus.DVALID) begin
        ndv++;
        if (lat < 0) begin
          lat = n - 1;
          dv_code = bus.DOUT;
        end
      end
    end
    bus.START = 1'b0;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; bus.START = 1'b0; bus.CONT = 1'b0; vin = '0;
    repeat (2) @(posedge CK);
    #1;
    checks++;
    if ({bus.SMP_CK, bus.CMP_CK, bus.DACP, bus.DOUT, bus.DVALID, bus.BUSY} !== '0)
      $display("FAIL reset_outputs: got smp=%b cmp=%b dacp=%h dout=%h dv=%b busy=%b, want all 0",
               bus.SMP_CK, bus.CMP_CK, bus.DACP, bus.DOUT, bus.DVALID, bus.BUSY);
    else passes++;
    RSTN = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge CK); #1;
      checks++;
      if ({bus.SMP_CK, bus.CMP_CK, bus.DACP, bus.DOUT, bus.DVALID, bus.BUSY} !== '0)
        $display("FAIL idle_outputs cyc %0d: got smp=%b cmp=%b dacp=%h dout=%h dv=%b busy=%b, want all 0",
                 n, bus.SMP_CK, bus.CMP_CK, bus.DACP, bus.DOUT, bus.DVALID, bus.BUSY);
      else passes++;
    end
  endtask

  task automatic test_single();
    int lat, smp, ns, ndv; logic [NB-1:0] ft, dc; logic ov;
    do_conv(10'h2A5, -1, -1, 30, lat, smp, ns, ft, ndv, dc, ov);
    checks++; if (lat !== LAT) $display("FAIL single_latency: got %0d want %0d", lat, LAT); else passes++;
    checks++; if (smp !== SMPC) $display("FAIL single_smp_cycles: got %0d want %0d", smp, SMPC); else passes++;
    checks++; if (ns !== NB) $display("FAIL single_strobes: got %0d want %0d", ns, NB); else passes++;
    checks++; if (dc !== 10'h2A5) $display("FAIL single_dout: got %h want 2a5", dc); else passes++;
    checks++; if (ndv !== 1) $display("FAIL single_dvalid_count: got %0d want 1", ndv); else passes++;
    checks++; if (ov !== 1'b0) $display("FAIL single_hold_overlap: got %b want 0", ov); else passes++;
    checks++; if (bus.BUSY !== 1'b0) $display("FAIL single_busy_after: got %b want 0", bus.BUSY); else passes++;
    checks++; if (bus.DOUT !== 10'h2A5) $display("FAIL single_dout_held: got %h want 2a5", bus.DOUT); else passes++;
  endtask

  task automatic test_extremes();
    int lat, smp, ns, ndv; logic [NB-1:0] ft, dc; logic ov;
    logic [NB-1:0] codes [2];
    codes[0] = 10'h000; codes[1] = 10'h3FF;
    for (int k = 0; k < 2; k++) begin
      do_conv(codes[k], -1, -1, 30, lat, smp, ns, ft, ndv, dc, ov);
      checks++; if (dc !== codes[k]) $display("FAIL extreme_dout: got %h want %h", dc, codes[k]); else passes++;
      checks++; if (ft !== 10'h200) $display("FAIL extreme_first_trial: got %h want 200", ft); else passes++;
    end
  endtask

  task automatic test_start_ignored();
    int lat, smp, ns, ndv; logic [NB-1:0] ft, dc; logic ov;
    // n=1: START still high at an edge in SAMPLE; n=13: high at the edge closing EVAL of bit 5
    do_conv(10'h2A5, 1, 13, 34, lat, smp, ns, ft, ndv, dc, ov);
    checks++; if (ndv !== 1) $display("FAIL busy_start_dvalid_count: got %0d want 1", ndv); else passes++;
    checks++; if (lat !== LAT) $display("FAIL busy_start_latency: got %0d want %0d", lat, LAT); else passes++;
    checks++; if (dc !== 10'h2A5) $display("FAIL busy_start_dout: got %h want 2a5", dc); else passes++;
  endtask

  task automatic test_abort();
    int lat, smp, ns, ndv; logic [NB-1:0] ft, dc; logic ov;
    logic [NB-1:0] v, want_trial;
    int dv_seen;
    v = 10'($urandom);
    vin = v;
    // Trial for bit 5: bits 9..6 already decided as in VIN, bit 5 set, lower bits clear
    want_trial = (v & 10'h3C0) | 10'h020;
    bus.START = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge CK); #1;
      bus.START = 1'b0;
    end
    checks++;
    if (bus.CMP_CK !== 1'b1 || bus.DACP !== want_trial)
      $display("FAIL abort_bit5_trial: got cmp=%b dacp=%h want cmp=1 dacp=%h", bus.CMP_CK, bus.DACP, want_trial);
    else passes++;
    RSTN = 1'b0;
    @(posedge CK); #1;
    RSTN = 1'b1;
    checks++;
    if ({bus.SMP_CK, bus.CMP_CK, bus.DACP, bus.DOUT, bus.DVALID, bus.BUSY} !== '0)
      $display("FAIL abort_outputs: got smp=%b cmp=%b dacp=%h dout=%h dv=%b busy=%b, want all 0",
               bus.SMP_CK, bus.CMP_CK, bus.DACP, bus.DOUT, bus.DVALID, bus.BUSY);
    else passes++;
    dv_seen = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge CK); #1;
      if (bus.DVALID || bus.BUSY) dv_seen++;
    end
    checks++; if (dv_seen !== 0) $display("FAIL abort_stays_idle: got %0d active cycles want 0", dv_seen); else passes++;
    do_conv(10'h155, -1, -1, 30, lat, smp, ns, ft, ndv, dc, ov);
    checks++; if (dc !== 10'h155) $display("FAIL abort_reconvert_dout: got %h want 155", dc); else passes++;
    checks++; if (lat !== LAT) $display("FAIL abort_reconvert_latency: got %0d want %0d", lat, LAT); else passes++;
  endtask

  task automatic test_free_run();
    logic [NB-1:0] vals [3];
    int k, prev, bad;
    vals[0] = 10'h001; vals[1] = 10'h1FF; vals[2] = 10'h200;
    k = 0; prev = 0; bad = 0;
    vin = vals[0];
    bus.CONT = 1'b1;
    bus.START = 1'b1;
    for (int n = 1; n <= 3 * PERIOD + 10 && k < 3; n++) begin
      @(posedge CK); #1;
      bus.START = 1'b0;
      // Outside SAMPLE the trial code is non-zero while busy, and the switch must be holding
      if (bus.BUSY && bus.DACP != '0 && bus.SMP_CK) bad++;
      if (bus.DVALID) begin
        checks++;
        if (bus.DOUT !== vals[k]) $display("FAIL free_run_dout %0d: got %h want %h", k, bus.DOUT, vals[k]);
        else passes++;
        checks++;
        if ((n - prev) !== ((k == 0) ? LAT + 1 : PERIOD))
          $display("FAIL free_run_spacing %0d: got %0d want %0d", k, n - prev, (k == 0) ? LAT + 1 : PERIOD);
        else passes++;
        prev = n;
        k++;
        if (k < 3) vin = vals[k];
        else bus.CONT = 1'b0;
      end
    end
    bus.CONT = 1'b0;
    checks++; if (k !== 3) $display("FAIL free_run_count: got %0d results want 3", k); else passes++;
    checks++; if (bad !== 0) $display("FAIL free_run_hold: got %0d cycles tracking during conversion want 0", bad); else passes++;
    repeat (3) @(posedge CK); #1;
    checks++; if (bus.BUSY !== 1'b0) $display("FAIL free_run_stop: got busy=%b want 0", bus.BUSY); else passes++;
  endtask

  task automatic test_random();
    int lat, smp, ns, ndv; logic [NB-1:0] ft, dc, v; logic ov;
    for (int r = 0; r < 8; r++) begin
      v = 10'($urandom_range(0, 1023));
      do_conv(v, -1, -1, 26, lat, smp, ns, ft, ndv, dc, ov);
      checks++;
      if (dc !== v || lat !== LAT)
        $display("FAIL random_conv %0d: got dout=%h lat=%0d want dout=%h lat=%0d", r, dc, lat, v, LAT);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_start_ignored();
    test_abort();
    test_free_run();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
